// File: rtl/hk_pkg.sv
// Shared keycodes, state encodings and helpers for the player input path.
package hk_pkg;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_L     = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ATTACK   = 2'd1,
    ST_DASH     = 2'd2,
    ST_COOLDOWN = 2'd3
  } action_state_t;

  typedef enum logic [1:0] {
    MOVE_NONE  = 2'b00,
    MOVE_LEFT  = 2'b01,
    MOVE_RIGHT = 2'b10
  } move_dir_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Remembers last frame's keycode and decodes per-key held/press strobes.
module key_edge_det
  import hk_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       held_left_c,
  output logic       held_right_c,
  output logic       held_jump_c,
  output logic       press_jump_c,
  output logic       press_attack_c,
  output logic       press_dash_c
);

  logic [7:0] prev_key;

  // Previous-frame keycode register
  always_ff @(posedge frame_clk) begin
    if (Reset) prev_key <= 8'h00;
    else       prev_key <= keycode;
  end

  // Held = key present now; press = key present now but not last frame
  always_comb begin
    held_left_c    = (keycode == KEY_A);
    held_right_c   = (keycode == KEY_D);
    held_jump_c    = (keycode == KEY_SPACE);
    press_jump_c   = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);
    press_attack_c = (keycode == KEY_J)     && (prev_key != KEY_J);
    press_dash_c   = (keycode == KEY_L)     && (prev_key != KEY_L);
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Per-frame keycode to player command conversion: movement, buffered jump, timed attack/dash.
module player_input_ctrl
  import hk_pkg::*;
#(
  parameter int unsigned ATTACK_FRAMES = 6,
  parameter int unsigned DASH_FRAMES   = 8,
  parameter int unsigned COOLDOWN      = 10,
  parameter int unsigned JUMP_HOLD_MAX = 12,
  parameter int unsigned JUMP_BUF      = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       on_ground,
  output logic [1:0] move_dir,
  output logic       facing,
  output logic       jump_start,
  output logic       jump_hold,
  output logic       attack_active,
  output logic       dash_active,
  output logic       busy
);

  localparam int unsigned ACT_MAX = max_u(max_u(ATTACK_FRAMES, DASH_FRAMES), COOLDOWN);
  localparam int unsigned ACT_W   = $clog2(ACT_MAX + 1);
  localparam int unsigned HOLD_W  = $clog2(JUMP_HOLD_MAX + 1);
  localparam int unsigned BUF_W   = $clog2(JUMP_BUF + 1);

  logic held_left_c, held_right_c, held_jump_c;
  logic press_jump_c, press_attack_c, press_dash_c;

  action_state_t     state;
  logic [ACT_W-1:0]  act_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt_c;
  logic [BUF_W-1:0]  buf_cnt, buf_nxt_c;
  logic              launch_c;
  move_dir_t         dir_c;

  key_edge_det u_key_edge_det (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .held_left_c    (held_left_c),
    .held_right_c   (held_right_c),
    .held_jump_c    (held_jump_c),
    .press_jump_c   (press_jump_c),
    .press_attack_c (press_attack_c),
    .press_dash_c   (press_dash_c)
  );

  // Requested horizontal direction from the held key
  always_comb begin
    dir_c = MOVE_NONE;
    if (held_left_c)       dir_c = MOVE_LEFT;
    else if (held_right_c) dir_c = MOVE_RIGHT;
  end

  // Action FSM; move_dir lives here because a dash overrides it
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      act_cnt       <= '0;
      attack_active <= 1'b0;
      dash_active   <= 1'b0;
      busy          <= 1'b0;
      move_dir      <= MOVE_NONE;
    end else begin
      move_dir <= dir_c;
      case (state)
        ST_IDLE: begin
          if (press_attack_c) begin
            state         <= ST_ATTACK;
            act_cnt       <= ACT_W'(ATTACK_FRAMES - 1);
            attack_active <= 1'b1;
            busy          <= 1'b1;
          end else if (press_dash_c) begin
            state       <= ST_DASH;
            act_cnt     <= ACT_W'(DASH_FRAMES - 1);
            dash_active <= 1'b1;
            busy        <= 1'b1;
            move_dir    <= MOVE_NONE;
          end
        end
        ST_ATTACK: begin
          if (act_cnt == '0) begin
            state         <= ST_COOLDOWN;
            act_cnt       <= ACT_W'(COOLDOWN - 1);
            attack_active <= 1'b0;
          end else begin
            act_cnt <= act_cnt - ACT_W'(1);
          end
        end
        ST_DASH: begin
          if (act_cnt == '0) begin
            state       <= ST_COOLDOWN;
            act_cnt     <= ACT_W'(COOLDOWN - 1);
            dash_active <= 1'b0;
          end else begin
            act_cnt  <= act_cnt - ACT_W'(1);
            move_dir <= MOVE_NONE;
          end
        end
        ST_COOLDOWN: begin
          if (act_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            act_cnt <= act_cnt - ACT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Facing follows the last horizontal key
  always_ff @(posedge frame_clk) begin
    if (Reset)             facing <= 1'b1;
    else if (held_left_c)  facing <= 1'b0;
    else if (held_right_c) facing <= 1'b1;
  end

  // Jump launch decision plus next hold-window and buffer counts
  always_comb begin
    launch_c   = !jump_start && on_ground && (press_jump_c || (buf_cnt != '0));
    hold_nxt_c = hold_cnt;
    buf_nxt_c  = buf_cnt;
    if (launch_c)            hold_nxt_c = held_jump_c ? HOLD_W'(JUMP_HOLD_MAX) : '0;
    else if (!held_jump_c)   hold_nxt_c = '0;
    else if (hold_cnt != '0) hold_nxt_c = hold_cnt - HOLD_W'(1);
    if (launch_c)                       buf_nxt_c = '0;
    else if (press_jump_c && !on_ground) buf_nxt_c = BUF_W'(JUMP_BUF);
    else if (buf_cnt != '0)             buf_nxt_c = buf_cnt - BUF_W'(1);
  end

  // Jump registers
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      jump_start <= 1'b0;
      jump_hold  <= 1'b0;
      hold_cnt   <= '0;
      buf_cnt    <= '0;
    end else begin
      jump_start <= launch_c;
      jump_hold  <= held_jump_c && (hold_nxt_c != '0);
      hold_cnt   <= hold_nxt_c;
      buf_cnt    <= buf_nxt_c;
    end
  end

endmodule
